// File: rtl/div_issue_queue.sv
// rtl/div_issue_queue.sv - reservation-station queue feeding the divide unit
// Age-ordered, compacted entry array with CDB wakeup and oldest-ready issue.
module div_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              dispatch_en,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_data,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic              dispatch_rs1_rdy,
  input  logic [DATA_W-1:0] dispatch_rs2_data,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic              dispatch_rs2_rdy,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_result,
  input  logic              read_enable,
  output logic              issue_queue_rdy,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic              queue_full,
  output logic              queue_empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_n;
  logic [TAG_W-1:0]  rd_tag_q   [DEPTH];
  logic [DATA_W-1:0] rs1_data_q [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_q  [DEPTH];
  logic              rs1_rdy_q  [DEPTH];
  logic [DATA_W-1:0] rs2_data_q [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_q  [DEPTH];
  logic              rs2_rdy_q  [DEPTH];

  logic [DATA_W-1:0] w_rs1_data [DEPTH];
  logic              w_rs1_rdy  [DEPTH];
  logic [DATA_W-1:0] w_rs2_data [DEPTH];
  logic              w_rs2_rdy  [DEPTH];

  logic [TAG_W-1:0]  rd_tag_n   [DEPTH];
  logic [DATA_W-1:0] rs1_data_n [DEPTH];
  logic [TAG_W-1:0]  rs1_tag_n  [DEPTH];
  logic              rs1_rdy_n  [DEPTH];
  logic [DATA_W-1:0] rs2_data_n [DEPTH];
  logic [TAG_W-1:0]  rs2_tag_n  [DEPTH];
  logic              rs2_rdy_n  [DEPTH];

  logic              offer_hit;
  logic [IDX_W-1:0]  offer_idx;
  logic              pop;
  logic              accept;
  logic [CNT_W-1:0]  tail;
  logic              byp1, byp2;

  // Scan from the top so the lowest ready index wins.
  always_comb begin
    offer_hit = 1'b0;
    offer_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CNT_W'(i) < count_q && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
        offer_hit = 1'b1;
        offer_idx = IDX_W'(i);
      end
    end
  end

  assign issue_queue_rdy = offer_hit;
  assign issue_rd_tag    = offer_hit ? rd_tag_q[offer_idx]   : '0;
  assign issue_rs1_data  = offer_hit ? rs1_data_q[offer_idx] : '0;
  assign issue_rs2_data  = offer_hit ? rs2_data_q[offer_idx] : '0;
  assign queue_full      = (count_q == CNT_W'(DEPTH));
  assign queue_empty     = (count_q == '0);

  assign pop    = offer_hit & read_enable;
  assign accept = dispatch_en & (~queue_full | pop);
  assign tail   = count_q - CNT_W'(pop);
  assign byp1   = ~dispatch_rs1_rdy & cdb_valid & (dispatch_rs1_tag == cdb_tag);
  assign byp2   = ~dispatch_rs2_rdy & cdb_valid & (dispatch_rs2_tag == cdb_tag);

  // Wakeup is applied before the shift so a shifted entry keeps the broadcast.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rs1_data[i] = rs1_data_q[i];
      w_rs1_rdy[i]  = rs1_rdy_q[i];
      w_rs2_data[i] = rs2_data_q[i];
      w_rs2_rdy[i]  = rs2_rdy_q[i];
      if (cdb_valid && !rs1_rdy_q[i] && rs1_tag_q[i] == cdb_tag) begin
        w_rs1_data[i] = cdb_result;
        w_rs1_rdy[i]  = 1'b1;
      end
      if (cdb_valid && !rs2_rdy_q[i] && rs2_tag_q[i] == cdb_tag) begin
        w_rs2_data[i] = cdb_result;
        w_rs2_rdy[i]  = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = i;
      if (pop && IDX_W'(i) >= offer_idx && i < DEPTH - 1) src = i + 1;
      rd_tag_n[i]   = rd_tag_q[src];
      rs1_data_n[i] = w_rs1_data[src];
      rs1_tag_n[i]  = rs1_tag_q[src];
      rs1_rdy_n[i]  = w_rs1_rdy[src];
      rs2_data_n[i] = w_rs2_data[src];
      rs2_tag_n[i]  = rs2_tag_q[src];
      rs2_rdy_n[i]  = w_rs2_rdy[src];
      if (accept && CNT_W'(i) == tail) begin
        rd_tag_n[i]   = dispatch_rd_tag;
        rs1_data_n[i] = byp1 ? cdb_result : dispatch_rs1_data;
        rs1_tag_n[i]  = dispatch_rs1_tag;
        rs1_rdy_n[i]  = dispatch_rs1_rdy | byp1;
        rs2_data_n[i] = byp2 ? cdb_result : dispatch_rs2_data;
        rs2_tag_n[i]  = dispatch_rs2_tag;
        rs2_rdy_n[i]  = dispatch_rs2_rdy | byp2;
      end
    end
    count_n = flush ? '0 : count_q + CNT_W'(accept) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_tag_q[i]   <= '0;
        rs1_data_q[i] <= '0;
        rs1_tag_q[i]  <= '0;
        rs1_rdy_q[i]  <= 1'b0;
        rs2_data_q[i] <= '0;
        rs2_tag_q[i]  <= '0;
        rs2_rdy_q[i]  <= 1'b0;
      end
    end else begin
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) begin
        rd_tag_q[i]   <= rd_tag_n[i];
        rs1_data_q[i] <= rs1_data_n[i];
        rs1_tag_q[i]  <= rs1_tag_n[i];
        rs1_rdy_q[i]  <= rs1_rdy_n[i];
        rs2_data_q[i] <= rs2_data_n[i];
        rs2_tag_q[i]  <= rs2_tag_n[i];
        rs2_rdy_q[i]  <= rs2_rdy_n[i];
      end
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// tb/tb_div_issue_queue.sv - directed vector bench for div_issue_queue
module tb_div_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, dispatch_en;
  logic [5:0]  dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag, cdb_tag;
  logic [31:0] dispatch_rs1_data, dispatch_rs2_data, cdb_result;
  logic        dispatch_rs1_rdy, dispatch_rs2_rdy, cdb_valid, read_enable;
  logic        issue_queue_rdy, queue_full, queue_empty;
  logic [5:0]  issue_rd_tag;
  logic [31:0] issue_rs1_data, issue_rs2_data;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  div_issue_queue #(.DEPTH(4), .DATA_W(32), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .dispatch_en(dispatch_en),
    .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs1_rdy(dispatch_rs1_rdy),
    .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs2_rdy(dispatch_rs2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .read_enable(read_enable), .issue_queue_rdy(issue_queue_rdy),
    .issue_rd_tag(issue_rd_tag), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .queue_full(queue_full),
    .queue_empty(queue_empty)
  );

  typedef struct {
    logic        flush;
    logic        den;
    logic [5:0]  drd;
    logic [31:0] d1;
    logic [5:0]  t1;
    logic        r1;
    logic [31:0] d2;
    logic [5:0]  t2;
    logic        r2;
    logic        cv;
    logic [5:0]  ct;
    logic [31:0] cr;
    logic        re;
    logic        e_rdy;
    logic [5:0]  e_tag;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic [5:0] t,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic full, input logic empty);
    chk({tag, ".issue_queue_rdy"}, 32'(issue_queue_rdy), 32'(rdy));
    chk({tag, ".issue_rd_tag"},    32'(issue_rd_tag),    32'(t));
    chk({tag, ".issue_rs1_data"},  issue_rs1_data,       d1);
    chk({tag, ".issue_rs2_data"},  issue_rs2_data,       d2);
    chk({tag, ".queue_full"},      32'(queue_full),      32'(full));
    chk({tag, ".queue_empty"},     32'(queue_empty),     32'(empty));
  endtask

  task automatic idle_inputs();
    flush = 0; dispatch_en = 0; dispatch_rd_tag = 0;
    dispatch_rs1_data = 0; dispatch_rs1_tag = 0; dispatch_rs1_rdy = 0;
    dispatch_rs2_data = 0; dispatch_rs2_tag = 0; dispatch_rs2_rdy = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_result = 0; read_enable = 0;
  endtask

  initial begin
    // flush den rd d1 t1 r1 d2 t2 r2 cv ct cr re | rdy tag d1 d2 full empty
    vecs.push_back(vec_t'{0,1,5,100,0,1,7,0,1,0,0,0,0,   1,5,100,7,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     0,0,0,0,0,1});
    vecs.push_back(vec_t'{0,1,3,50,0,1,0,9,0,0,0,0,0,    0,0,0,0,0,0});
    vecs.push_back(vec_t'{0,1,4,20,0,1,4,0,1,0,0,0,0,    1,4,20,4,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,9,2,1,     1,3,50,2,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     0,0,0,0,0,1});
    vecs.push_back(vec_t'{0,1,8,0,12,0,3,0,1,1,12,32'h40,0, 1,8,32'h40,3,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     0,0,0,0,0,1});
    vecs.push_back(vec_t'{0,1,20,1000,0,1,10,0,1,0,0,0,0, 1,20,1000,10,0,0});
    vecs.push_back(vec_t'{0,1,21,2100,0,1,21,0,1,0,0,0,0, 1,20,1000,10,0,0});
    vecs.push_back(vec_t'{0,1,22,2200,0,1,22,0,1,0,0,0,0, 1,20,1000,10,0,0});
    vecs.push_back(vec_t'{0,1,23,2300,0,1,23,0,1,0,0,0,0, 1,20,1000,10,1,0});
    vecs.push_back(vec_t'{0,1,24,2400,0,1,24,0,1,0,0,0,1, 1,21,2100,21,1,0});
    vecs.push_back(vec_t'{0,1,25,2500,0,1,25,0,1,0,0,0,0, 1,21,2100,21,1,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     1,22,2200,22,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     1,23,2300,23,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     1,24,2400,24,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     0,0,0,0,0,1});
    vecs.push_back(vec_t'{0,1,30,9,0,1,3,0,1,0,0,0,0,    1,30,9,3,0,0});
    vecs.push_back(vec_t'{0,1,31,0,7,0,5,0,1,0,0,0,0,    1,30,9,3,0,0});
    vecs.push_back(vec_t'{0,1,32,6,0,1,0,7,0,0,0,0,0,    1,30,9,3,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,1,7,11,1,    1,31,11,5,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     1,32,6,11,0,0});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     0,0,0,0,0,1});
    vecs.push_back(vec_t'{0,1,40,1,0,1,2,0,1,0,0,0,0,    1,40,1,2,0,0});
    vecs.push_back(vec_t'{0,1,41,3,0,1,4,0,1,0,0,0,0,    1,40,1,2,0,0});
    vecs.push_back(vec_t'{0,1,42,5,0,1,6,0,1,0,0,0,0,    1,40,1,2,0,0});
    vecs.push_back(vec_t'{1,1,43,7,0,1,8,0,1,1,7,9,1,    0,0,0,0,0,1});
    vecs.push_back(vec_t'{0,0,0,0,0,0,0,0,0,0,0,0,1,     0,0,0,0,0,1});

    idle_inputs();
    rst_n = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[k]) begin
      @(negedge clk);
      flush = vecs[k].flush; dispatch_en = vecs[k].den; dispatch_rd_tag = vecs[k].drd;
      dispatch_rs1_data = vecs[k].d1; dispatch_rs1_tag = vecs[k].t1; dispatch_rs1_rdy = vecs[k].r1;
      dispatch_rs2_data = vecs[k].d2; dispatch_rs2_tag = vecs[k].t2; dispatch_rs2_rdy = vecs[k].r2;
      cdb_valid = vecs[k].cv; cdb_tag = vecs[k].ct; cdb_result = vecs[k].cr;
      read_enable = vecs[k].re;
      #1;
      if (dispatch_en && queue_full && !(read_enable && issue_queue_rdy) && !flush)
        $display("note: vector %0d dispatches into a full queue (dropped)", k);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", k), vecs[k].e_rdy, vecs[k].e_tag, vecs[k].e_d1,
              vecs[k].e_d2, vecs[k].e_full, vecs[k].e_empty);
    end

    // Asynchronous reset between edges must clear outputs without a clock.
    @(negedge clk);
    idle_inputs();
    dispatch_en = 1; dispatch_rd_tag = 50;
    dispatch_rs1_data = 77; dispatch_rs1_rdy = 1;
    dispatch_rs2_data = 88; dispatch_rs2_rdy = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    chk_all("pre_rst", 1, 50, 77, 88, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- Reservation-station queue feeding the divide execution unit.
- Holds dispatched divide instructions until both source operands are available, capturing late operands by snooping the CDB.
- Each cycle it offers the oldest ready entry to the divide unit, which pops it with a read strobe.
- Producer side of the divide unit's issue_queue_rdy / operand-data / read_enable handshake.

Parameters:
DEPTH  4  number of queue entries (power of two, >=2)
DATA_W  32  operand/result width
TAG_W  6  ROB/physical tag width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all entries
dispatch_en  input  1  write one new entry this cycle
dispatch_rd_tag  input  TAG_W  destination tag
dispatch_rs1_data  input  DATA_W  rs1 value (valid when rs1_rdy=1)
dispatch_rs1_tag  input  TAG_W  rs1 producer tag (used when rs1_rdy=0)
dispatch_rs1_rdy  input  1  rs1 value already available
dispatch_rs2_data  input  DATA_W  rs2 value
dispatch_rs2_tag  input  TAG_W  rs2 producer tag
dispatch_rs2_rdy  input  1  rs2 value already available
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB broadcast tag
cdb_result  input  DATA_W  CDB broadcast value
read_enable  input  1  divide unit accepts offered entry
issue_queue_rdy  output  1  an entry with both operands ready is offered
issue_rd_tag  output  TAG_W  offered destination tag
issue_rs1_data  output  DATA_W  offered dividend
issue_rs2_data  output  DATA_W  offered divisor
queue_full  output  1  count == DEPTH
queue_empty  output  1  count == 0

Behaviour:
- Reset (async, rst_n=0): all entries invalid, count=0. Outputs: issue_queue_rdy=0, issue_* = 0, queue_full=0, queue_empty=1.
- Storage: age-ordered array, index 0 = oldest. Valid entries are always compacted at indices 0..count-1.
  - Per entry: rd_tag, rs1/rs2 {data, tag, rdy}.
- Offer (combinational from registered state):
  - issue_queue_rdy=1 iff some valid entry has rs1_rdy & rs2_rdy.
  - issue_* come from the lowest-index such entry; all zero when none.
- Pop: when issue_queue_rdy & read_enable at a clock edge, the offered entry is removed.
  - Entries above it shift down one index, preserving order.
  - read_enable with issue_queue_rdy=0 is ignored.
- Dispatch: when dispatch_en & (!queue_full | pop this cycle), the new entry is written at the tail.
  - The tail index is computed after the pop shift, i.e. at count-pop.
  - dispatch_en while full with no pop: dropped, state unchanged. Illegal for the dispatcher; the bench flags it.
- Wakeup: on each edge with cdb_valid, every valid entry operand with rdy=0 and tag==cdb_tag latches data=cdb_result and sets rdy=1.
  - Both operands of one entry may wake on the same broadcast.
  - Woken entries become eligible to be offered the next cycle. No same-cycle CDB-to-issue bypass.
- Dispatch bypass: if a dispatched operand has rdy=0 and cdb_valid with cdb_tag matching its tag, it is written with rdy=1 and data=cdb_result.
- Simultaneous pop and wakeup of the shifting entries: the wakeup is applied to the shifted-down copy. No broadcast is lost.
- Flush: synchronous, clears all valid bits and sets count=0 at the edge. Overrides dispatch, pop and wakeup in the same cycle.
- Count: width $clog2(DEPTH+1).
  - Next count = count + dispatch_accepted - pop.
  - Simultaneous pop and dispatch when full: count stays DEPTH.
- Reset mid-operation: asynchronous clear. The outputs are zero immediately, not waiting for the next edge.
- Data is not interpreted. Divide-by-zero and sign handling belong to the divide unit.

Test Plan:
- Reset, then dispatch tag 5 with rs1=100/rdy, rs2=7/rdy -> next cycle issue_queue_rdy=1, rd_tag=5, data 100/7. Pulse read_enable -> queue_empty=1 the following cycle.
- Dispatch tag 3 (rs2 waiting on tag 9), then tag 4 (both ready) -> tag 4 offered first. CDB {9, 2} -> tag 3 offered one cycle later after tag 4 pops.
- Dispatch rs1 waiting on tag 12 in the same cycle as CDB {12, 0x40} -> entry stored ready, offered next cycle with rs1=0x40.
- Fill 4 entries -> queue_full=1. Dispatch plus pop in the same cycle -> count stays 4 and the new entry lands at index 3. Dispatch without pop -> entry dropped.
- Two entries both waiting on tag 7. Pop index 0 in the same cycle as CDB {7, 11} -> the remaining entries hold 11 and become ready, order preserved.
- Three entries, assert flush together with dispatch_en -> queue_empty=1, issue_queue_rdy=0. Assert rst_n=0 mid-stream -> outputs zero immediately.
